gf2m_itoh_tsujii_inverter: RTL and testbench

Parametrised GF(2^M) multiplicative inverter for the ECC datapath, replacing the fixed 163-bit inversion block. It computes a^-1 = a^(2^M - 2) with the Itoh-Tsujii addition chain, which is derived from M at elaboration time. The datapath is one internal polynomial-basis field multiplier and one single-step squarer. A start/busy/done handshake gives a constant-time, data-independent latency. The block sits between the point-arithmetic controller and the affine-conversion stage.

---
 rtl/gf2m_itoh_tsujii_inverter.sv | 158 +++++++++++++++
 tb/tb_gf2m_itoh_tsujii_inverter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_itoh_tsujii_inverter.sv
// GF(2^M) inverter: a^(2^M-2) via an Itoh-Tsujii addition chain.
// One shared field multiplier and one single-step squarer, fixed latency.
module gf2m_itoh_tsujii_inverter #(
  parameter int             M       = 163,
  parameter logic [M-1:0]   POLY    = M'(8'hC9),
  parameter int             CHAIN_W = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] inv_out,
  output logic         zero_in
);

  localparam logic [CHAIN_W-1:0] E    = CHAIN_W'(M - 1);
  localparam logic [CHAIN_W-1:0] BIT0 = CHAIN_W'(CHAIN_W - 2);
  localparam logic [CHAIN_W-1:0] K1   = CHAIN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DBL_SQR,
    S_DBL_MUL,
    S_ADD_SQR,
    S_ADD_MUL,
    S_FIN_SQR,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [M-1:0]       a_r, y, t;
  logic [CHAIN_W-1:0] k, sq_cnt, bit_idx;
  logic [CHAIN_W-1:0] k2, k_inc;
  logic [M-1:0]       sqr_in, sqr_out, mul_b, mul_out;
  logic               e_bit, last;

  function automatic logic [M-1:0] gf_mul(
    input logic [M-1:0] x,
    input logic [M-1:0] z
  );
    logic [M-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
      if (z[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] x);
    logic [2*M-1:0] v;
    v = '0;
    for (int i = 0; i < M; i++) v[2*i] = x[i];
    for (int i = 2 * M - 2; i >= M; i--) begin
      if (v[i]) begin
        v[i]         = 1'b0;
        v[i-M +: M]  = v[i-M +: M] ^ POLY;
      end
    end
    return v[M-1:0];
  endfunction

  // Operand muxes for the single shared squarer and multiplier
  always_comb begin
    sqr_in  = (state == S_DBL_SQR) ? t : y;
    mul_b   = (state == S_ADD_MUL) ? a_r : y;
    sqr_out = gf_sqr(sqr_in);
    mul_out = gf_mul(t, mul_b);
    e_bit   = |(E & (K1 << bit_idx));
    last    = (bit_idx == '0);
    k2      = {k[CHAIN_W-2:0], 1'b0};
    k_inc   = k + K1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_DBL_SQR;
      S_DBL_SQR: if (sq_cnt == K1) state_nx = S_DBL_MUL;
      S_DBL_MUL: begin
        if (e_bit)     state_nx = S_ADD_SQR;
        else if (last) state_nx = S_FIN_SQR;
        else           state_nx = S_DBL_SQR;
      end
      S_ADD_SQR: state_nx = S_ADD_MUL;
      S_ADD_MUL: state_nx = last ? S_FIN_SQR : S_DBL_SQR;
      S_FIN_SQR: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      y       <= '0;
      t       <= '0;
      k       <= '0;
      sq_cnt  <= '0;
      bit_idx <= '0;
      inv_out <= '0;
      zero_in <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_r     <= a_in;
            y       <= a_in;
            t       <= a_in;
            k       <= K1;
            sq_cnt  <= K1;
            bit_idx <= BIT0;
          end
        end
        S_DBL_SQR: begin
          t      <= sqr_out;
          sq_cnt <= sq_cnt - K1;
        end
        S_DBL_MUL: begin
          y      <= mul_out;
          t      <= mul_out;
          k      <= k2;
          sq_cnt <= k2;
          if (!e_bit && !last) bit_idx <= bit_idx - K1;
        end
        S_ADD_SQR: t <= sqr_out;
        S_ADD_MUL: begin
          y      <= mul_out;
          t      <= mul_out;
          k      <= k_inc;
          sq_cnt <= k_inc;
          if (!last) bit_idx <= bit_idx - K1;
        end
        // Result is registered here so it is valid throughout the done cycle
        S_FIN_SQR: begin
          y       <= sqr_out;
          inv_out <= sqr_out;
          zero_in <= (a_r == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_itoh_tsujii_inverter.sv
// Directed bench for the Itoh-Tsujii inverter at M=163 and M=7.
// Expected values are hand-derived or checked via a*inv == 1.
module tb_gf2m_itoh_tsujii_inverter;

  localparam logic [162:0] P163  = 163'hC9;
  localparam logic [162:0] P7    = 163'h03;
  localparam logic [162:0] INV_X = (163'd1 << 162) | 163'h64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         start_a = 1'b0;
  logic [162:0] a_a = '0;
  logic         busy_a, done_a, zero_a;
  logic [162:0] inv_a;

  logic         start_b = 1'b0;
  logic [6:0]   a_b = '0;
  logic         busy_b, done_b, zero_b;
  logic [6:0]   inv_b;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  gf2m_itoh_tsujii_inverter #(.M(163), .POLY(163'hC9)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .a_in(a_a),
    .busy(busy_a), .done(done_a), .inv_out(inv_a), .zero_in(zero_a)
  );

  gf2m_itoh_tsujii_inverter #(.M(7), .POLY(7'h03)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .a_in(a_b),
    .busy(busy_b), .done(done_b), .inv_out(inv_b), .zero_in(zero_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [162:0] got,
                     input logic [162:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [162:0] mulm(input logic [162:0] x,
                                        input logic [162:0] z,
                                        input int m,
                                        input logic [162:0] poly);
    logic [325:0] p;
    p = '0;
    for (int i = 0; i < m; i++)
      if (z[i]) p = p ^ ({163'b0, x} << i);
    for (int i = 2 * m - 2; i >= m; i--) begin
      if (p[i]) begin
        p    = p ^ ({163'b0, poly} << (i - m));
        p[i] = 1'b0;
      end
    end
    return p[162:0];
  endfunction

  task automatic go_a(input logic [162:0] a);
    while (busy_a) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    a_a = a;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    a_a = ~a;
  endtask

  task automatic wait_a(output int lat);
    lat = 1;
    while (!done_a && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, cnt, prev;
    logic [191:0] r;
    logic [162:0] op;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_inv_a", inv_a, 0);
    chk("rst_zero_a", zero_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_inv_b", inv_b, 0);
    @(negedge clk) rst_n = 1'b1;

    go_a(163'h2);
    chk("busy_after_accept", busy_a, 1);
    wait_a(lat);
    chk("lat_x", lat, 172);
    chk("inv_x", inv_a, INV_X);
    chk("zero_x", zero_a, 0);
    @(posedge clk); #1;
    chk("busy_cleared", busy_a, 0);
    chk("inv_held", inv_a, INV_X);

    go_a(163'h1);
    wait_a(lat);
    chk("lat_one", lat, 172);
    chk("inv_one", inv_a, 1);

    for (int i = 0; i < 20; i++) begin
      r  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      op = r[162:0];
      if (op == '0) op = 163'h1;
      go_a(op);
      wait_a(lat);
      chk("lat_rand", lat, 172);
      chk("rand_prod", mulm(inv_a, op, 163, P163), 1);
    end

    go_a(163'h0);
    wait_a(lat);
    chk("lat_zero", lat, 172);
    chk("inv_zero", inv_a, 0);
    chk("zero_flag", zero_a, 1);
    go_a(163'h1);
    wait_a(lat);
    chk("zero_cleared", zero_a, 0);
    chk("inv_after_zero", inv_a, 1);

    // start and a_in hammered while busy
    while (busy_a) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    a_a = 163'h2;
    start_a = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    cnt = 0;
    while (!done_a && lat < 400) begin
      @(negedge clk);
      start_a = 1'b1;
      a_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    chk("lat_spam", lat, 172);
    chk("inv_spam", inv_a, INV_X);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    chk("start_in_done", busy_a, 0);
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_a || busy_a) cnt++;
    end
    chk("no_extra_done", cnt, 0);

    // asynchronous reset at cycle 80
    go_a(163'h2);
    lat = 1;
    while (lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_inv", inv_a, 0);
    chk("arst_zero", zero_a, 0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done_a || busy_a) cnt++;
    end
    chk("no_done_after_rst", cnt, 0);
    go_a(163'h2);
    wait_a(lat);
    chk("lat_post_rst", lat, 172);
    chk("inv_post_rst", inv_a, INV_X);

    // M=7: every nonzero operand back-to-back
    @(negedge clk);
    a_b = 7'h01;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    prev = -1;
    for (int a = 1; a < 128; a++) begin
      lat = 1;
      while (!done_b && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("lat7", lat, 10);
      chk("prod7", mulm(163'(inv_b), 163'(a), 7, P7), 1);
      if (a == 2) chk("inv7_x", inv_b, 7'h41);
      if (prev >= 0) chk("period7", cyc - prev, 11);
      prev = cyc;
      if (a < 127) begin
        @(posedge clk); #1;
        a_b = 7'(a + 1);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
